fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_pkg.sv | 45 ++++
 rtl/pc_reg.sv | 25 ++
 rtl/fetch_unit.sv | 79 +++++++
 tb/tb_fetch_unit.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage: data width,
// the NOP used as the IF/ID bubble, and the per-cycle action decode.
package fetch_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0033;
  localparam logic [XLEN-1:0] BUBBLE_PC = 32'h0000_0000;
  localparam logic [XLEN-1:0] BUBBLE_PC4 = 32'h0000_0004;
  localparam logic BUBBLE_VALID = 1'b0;
  localparam logic [XLEN-1:0] ALIGN_MASK = 32'hFFFF_FFFC;
  localparam logic [XLEN-1:0] PC_STEP = 32'h0000_0004;

  typedef enum logic [1:0] {
    ACT_RESET,
    ACT_REDIRECT,
    ACT_STALL,
    ACT_ADVANCE
  } fetch_action_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc4;
    logic [XLEN-1:0] inst;
    logic valid;
  } if_id_t;

  // Reset beats redirect beats stall; a redirect squashes even a stalled fetch.
  function automatic fetch_action_e decode_action(input logic rst, input logic branch_taken,
                                                  input logic stall);
    if (rst) return ACT_RESET;
    else if (branch_taken) return ACT_REDIRECT;
    else if (stall) return ACT_STALL;
    else return ACT_ADVANCE;
  endfunction

  function automatic if_id_t bubble();
    if_id_t b;
    b.pc = BUBBLE_PC;
    b.pc4 = BUBBLE_PC4;
    b.inst = NOP_INST;
    b.valid = BUBBLE_VALID;
    return b;
  endfunction

endpackage

// File: rtl/pc_reg.sv
// Fetch program counter with its next-PC selection (reset, redirect, hold, +4).
// The PC is always word aligned; the low two target bits are masked off.
module pc_reg
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  output logic [XLEN-1:0] pc
);

  always_ff @(posedge clk) begin
    case (decode_action(rst, branch_taken, stall))
      ACT_RESET:    pc <= RESET_PC & ALIGN_MASK;
      ACT_REDIRECT: pc <= branch_target & ALIGN_MASK;
      ACT_STALL:    pc <= pc;
      default:      pc <= pc + PC_STEP;
    endcase
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register plus the IF/ID pipeline register.
// Define FETCH_PERF_CNT_EN to add the fetch/stall performance counters.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int IMEM_AW = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               branch_taken,
  input  logic [XLEN-1:0]    branch_target,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [XLEN-1:0]    imem_data,
  output logic [XLEN-1:0]    pc,
  output logic [XLEN-1:0]    if_id_pc,
  output logic [XLEN-1:0]    if_id_pc4,
  output logic [XLEN-1:0]    if_id_inst,
  output logic               if_id_valid
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]        perf_fetch_cnt,
  output logic [31:0]        perf_stall_cnt
`endif
);

  fetch_action_e action;
  if_id_t if_id_q;

  assign action = decode_action(rst, branch_taken, stall);

  pc_reg #(
    .RESET_PC(RESET_PC)
  ) u_pc_reg (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .pc           (pc)
  );

  // Memory index drops the byte offset and wraps within the memory size.
  assign imem_addr = pc[IMEM_AW+1:2];

  always_ff @(posedge clk) begin
    case (action)
      ACT_RESET, ACT_REDIRECT: if_id_q <= bubble();
      ACT_STALL:               if_id_q <= if_id_q;
      default: begin
        if_id_q.pc    <= pc;
        if_id_q.pc4   <= pc + PC_STEP;
        if_id_q.inst  <= imem_data;
        if_id_q.valid <= 1'b1;
      end
    endcase
  end

  assign if_id_pc    = if_id_q.pc;
  assign if_id_pc4   = if_id_q.pc4;
  assign if_id_inst  = if_id_q.inst;
  assign if_id_valid = if_id_q.valid;

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk) begin
    case (action)
      ACT_RESET: begin
        perf_fetch_cnt <= '0;
        perf_stall_cnt <= '0;
      end
      ACT_STALL:   perf_stall_cnt <= perf_stall_cnt + 32'd1;
      ACT_ADVANCE: perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      default: ;
    endcase
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: two instances (reset PC 0 and 4) against a
// behavioural model; directed scenarios followed by randomized traffic.
module tb_fetch_unit;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] inst;
    logic        valid;
  } ifid_t;

  typedef struct packed {
    logic [31:0] pc_a;
    ifid_t       ifid_a;
    logic [31:0] pc_b;
    ifid_t       ifid_b;
    logic [31:0] fetch_cnt;
    logic [31:0] stall_cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic stall = 1'b0;
  logic branch_taken = 1'b0;
  logic [31:0] branch_target = '0;

  logic [5:0]  imem_addr_a, imem_addr_b;
  logic [31:0] imem_data_a, imem_data_b;
  logic [31:0] pc_a, pc_b;
  logic [31:0] if_id_pc_a, if_id_pc4_a, if_id_inst_a;
  logic [31:0] if_id_pc_b, if_id_pc4_b, if_id_inst_b;
  logic        if_id_valid_a, if_id_valid_b;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt_a, perf_stall_cnt_a, perf_fetch_cnt_b, perf_stall_cnt_b;
`endif

  logic [31:0] mem [64];

  int n_checks = 0;
  int n_fail = 0;
  exp_t exp_q[$];

  logic [31:0] m_pc_a, m_pc_b, m_fcnt, m_scnt;
  ifid_t m_ifid_a, m_ifid_b;

  always #5 clk = ~clk;

  assign imem_data_a = mem[imem_addr_a];
  assign imem_data_b = mem[imem_addr_b];

  fetch_unit #(.RESET_PC(32'h0000_0000), .IMEM_AW(6)) dut_a (
    .clk(clk), .rst(rst), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .imem_addr(imem_addr_a), .imem_data(imem_data_a),
    .pc(pc_a), .if_id_pc(if_id_pc_a), .if_id_pc4(if_id_pc4_a),
    .if_id_inst(if_id_inst_a), .if_id_valid(if_id_valid_a)
`ifdef FETCH_PERF_CNT_EN
    , .perf_fetch_cnt(perf_fetch_cnt_a), .perf_stall_cnt(perf_stall_cnt_a)
`endif
  );

  fetch_unit #(.RESET_PC(32'h0000_0004), .IMEM_AW(6)) dut_b (
    .clk(clk), .rst(rst), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .imem_addr(imem_addr_b), .imem_data(imem_data_b),
    .pc(pc_b), .if_id_pc(if_id_pc_b), .if_id_pc4(if_id_pc4_b),
    .if_id_inst(if_id_inst_b), .if_id_valid(if_id_valid_b)
`ifdef FETCH_PERF_CNT_EN
    , .perf_fetch_cnt(perf_fetch_cnt_b), .perf_stall_cnt(perf_stall_cnt_b)
`endif
  );

  // One fetch-stage step in plain terms: what the next PC and IF/ID contents are.
  task automatic model_step(input bit r, input bit s, input bit b, input logic [31:0] t,
                            input logic [31:0] rpc, inout logic [31:0] p, inout ifid_t q);
    ifid_t nop;
    nop.pc = 32'd0;
    nop.pc4 = 32'd4;
    nop.inst = 32'h0000_0033;
    nop.valid = 1'b0;
    if (r) begin
      p = rpc;
      q = nop;
    end else if (b) begin
      p = (t / 4) * 4;
      q = nop;
    end else if (!s) begin
      q.pc = p;
      q.pc4 = p + 32'd4;
      q.inst = mem[(p / 4) % 64];
      q.valid = 1'b1;
      p = p + 32'd4;
    end
  endtask

  task automatic applyStimulus(input bit r, input bit s, input bit b, input logic [31:0] t);
    exp_t e;
    rst = r;
    stall = s;
    branch_taken = b;
    branch_target = t;
    model_step(r, s, b, t, 32'h0, m_pc_a, m_ifid_a);
    model_step(r, s, b, t, 32'h4, m_pc_b, m_ifid_b);
    if (r) begin
      m_fcnt = 0;
      m_scnt = 0;
    end else if (!b && s) m_scnt = m_scnt + 1;
    else if (!b) m_fcnt = m_fcnt + 1;
    e.pc_a = m_pc_a;
    e.ifid_a = m_ifid_a;
    e.pc_b = m_pc_b;
    e.ifid_b = m_ifid_b;
    e.fetch_cnt = m_fcnt;
    e.stall_cnt = m_scnt;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic compare(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    compare("pc_a", pc_a, e.pc_a);
    compare("imem_addr_a", {26'd0, imem_addr_a}, (e.pc_a / 4) % 64);
    compare("if_id_pc_a", if_id_pc_a, e.ifid_a.pc);
    compare("if_id_pc4_a", if_id_pc4_a, e.ifid_a.pc4);
    compare("if_id_inst_a", if_id_inst_a, e.ifid_a.inst);
    compare("if_id_valid_a", {31'd0, if_id_valid_a}, {31'd0, e.ifid_a.valid});
    compare("pc_b", pc_b, e.pc_b);
    compare("imem_addr_b", {26'd0, imem_addr_b}, (e.pc_b / 4) % 64);
    compare("if_id_pc_b", if_id_pc_b, e.ifid_b.pc);
    compare("if_id_inst_b", if_id_inst_b, e.ifid_b.inst);
    compare("if_id_valid_b", {31'd0, if_id_valid_b}, {31'd0, e.ifid_b.valid});
`ifdef FETCH_PERF_CNT_EN
    compare("perf_fetch_cnt_a", perf_fetch_cnt_a, e.fetch_cnt);
    compare("perf_stall_cnt_a", perf_stall_cnt_a, e.stall_cnt);
    compare("perf_stall_cnt_b", perf_stall_cnt_b, e.stall_cnt);
`endif
  endtask

  // Monitor: registered outputs are settled by the falling edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) checkOutput(exp_q.pop_front());
  end

  initial begin
    bit r, s, b;
    logic [31:0] t;
    for (int i = 0; i < 64; i++) mem[i] = $urandom;
    m_pc_a = '0; m_pc_b = '0; m_fcnt = '0; m_scnt = '0;
    m_ifid_a = '0; m_ifid_b = '0;

    // Reset, free run to pc=8, stall three cycles, run on to pc=20.
    applyStimulus(1, 0, 0, 0);
    repeat (2) applyStimulus(0, 0, 0, 0);
    repeat (3) applyStimulus(0, 1, 0, 0);
    repeat (3) applyStimulus(0, 0, 0, 0);
    // Redirect with misaligned target, then redirect coincident with stall.
    applyStimulus(0, 0, 1, 32'h0000_0023);
    applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 1, 1, 32'h0000_0040);
    applyStimulus(0, 0, 0, 0);
    // Reset in the middle of a stall, and reset together with a branch.
    applyStimulus(0, 1, 0, 0);
    applyStimulus(1, 1, 0, 0);
    applyStimulus(0, 0, 0, 0);
    applyStimulus(1, 0, 1, 32'h0000_0080);
    applyStimulus(0, 0, 0, 0);
    // PC wrap at the top of the address space and imem index wrap.
    applyStimulus(0, 0, 1, 32'hFFFF_FFFC);
    repeat (2) applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 0, 1, 32'h0000_0100);
    applyStimulus(0, 0, 0, 0);

    for (int i = 0; i < 400; i++) begin
      r = ($urandom_range(0, 39) == 0);
      s = ($urandom_range(0, 3) == 0);
      b = ($urandom_range(0, 7) == 0);
      t = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                      : $urandom;
      applyStimulus(r, s, b, t);
    end

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL scoreboard_drain actual=%0d required=0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
